rr_wordmux: RTL and testbench
=============================

# rr_wordmux

Parametrised N-channel word multiplexer with round-robin arbitration, valid/ready handshaking and a registered output stage. It replaces the fixed 2:1 and 4:1 combinational word selectors wherever several producers share one 16-bit datapath: register-file write-back, memory request port, or debug bus. It takes the place of an externally driven select with internal fair arbitration and back-pressure.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1).
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), width of the channel index; derived, do not override.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous and active-high.
- i_valid  input  CHANNELS  per-channel request; bit k belongs to channel k.
- i_data  input  CHANNELS*WIDTH  flattened words; channel k occupies bits k*WIDTH .. k*WIDTH+WIDTH-1.
- o_ready  output  CHANNELS  one-hot grant; bit k high means channel k's word is accepted this cycle.
- o_valid  output  1  output register holds a word.
- o_data  output  WIDTH  registered selected word.
- o_chan  output  SEL_W  index of the channel that produced o_data.
- i_ready  input  1  downstream accepts o_data this cycle.
- i_lock  input  1  grant lock; present only with RR_WORDMUX_LOCK_EN.

## Operation
- Single-entry output register (o_valid, o_data, o_chan) and a round-robin pointer `last` (SEL_W bits).
- Slot free = !o_valid || i_ready (drain and refill in the same cycle is allowed).
- Arbitration is combinational. It searches channels last+1, last+2, … with wrap modulo CHANNELS and picks the first with i_valid high. The search wraps to `last` itself, so `last` is checked last.
- o_ready[g] = 1 only when the slot is free and channel g is the winner. All other bits are 0. o_ready is never asserted while i_rst is high.
- On a transfer (o_ready[g] && i_valid[g]):
  - o_data ← channel g word.
  - o_chan ← g.
  - o_valid ← 1.
  - last ← g.
- On a drain without a refill (o_valid && i_ready && no grant), o_valid ← 0. o_data and o_chan keep their previous values.
- When o_valid && !i_ready: the output register holds, no grant is issued, and `last` is unchanged.
- o_ready depends on i_valid and i_ready combinationally. Producers must not make i_valid depend on o_ready.
- A producer must hold i_valid and its data until it sees its o_ready bit. Deasserting i_valid before a grant is permitted; the request is simply withdrawn.
- Reset values:
  - o_valid = 0.
  - o_data = 0.
  - o_chan = 0.
  - last = CHANNELS-1, so channel 0 has first priority after reset.
- Reset asserted mid-operation discards any held word. No transfer completes in a cycle where i_rst is high.

## Timing
- Latency: a word accepted at edge n appears on o_data/o_valid after edge n, i.e. one cycle.
- Throughput: one word per cycle while i_ready stays high.
- Fairness: with all channels continuously valid and i_ready high, grants go 0,1,…,CHANNELS-1,0,… with no channel served twice before any other requester.
- A single active channel is granted every cycle (the wrap search finds it). No idle bubble is inserted.
- Simultaneous drain + refill: o_valid stays 1 and o_data changes to the new word on the same edge.
- Critical path: i_ready → slot free → o_ready. This path is acknowledged and kept combinational; no skid buffer.

## Configuration
- RR_WORDMUX_LOCK_EN defined:
  - The i_lock port exists.
  - While i_lock is high, only channel `last` is eligible, and the pointer does not advance. Other channels get no grant even if `last` is idle.
  - This is used for multi-word bursts.
  - The lock takes effect combinationally in the same cycle i_lock rises.
  - After reset, lock applies to channel CHANNELS-1.
- RR_WORDMUX_LOCK_EN undefined: no i_lock port, pure round-robin as described above.

## Test plan
- Reset: hold i_rst high 3 cycles with all i_valid=1 -> o_valid=0, o_data=0, o_chan=0, o_ready=0 every cycle. First grant after release goes to channel 0.
- Fair rotation: CHANNELS=4, all valid, channel k data = 16'h1000+k, i_ready=1 -> o_chan sequence 0,1,2,3,0,1, o_data tracks it, one word per cycle.
- Back-pressure: i_ready=0 for 5 cycles while channel 2 holds 16'hBEEF -> o_valid=1, o_data=16'hBEEF stable, o_ready=0 for all channels. On i_ready=1, the next grant goes to channel 3 in the same cycle.
- Sparse/wrap: only channel 1 valid for 4 cycles, then only channel 0 -> four consecutive grants to 1 with no bubbles, then channel 0 granted the next cycle.
- Drain without refill: one word in the register, no i_valid, i_ready=1 -> o_valid falls after one edge and o_data keeps its old value. Mid-stream reset drops o_valid the next edge.
- Lock (RR_WORDMUX_LOCK_EN, CHANNELS=4): grant channel 2, raise i_lock with all valid -> channel 2 is granted 3 cycles running. Drop i_lock -> the next grant goes to channel 3.

Source files
------------

// File: rtl/rr_wordmux.sv
// N-channel word multiplexer: round-robin arbitration, valid/ready handshake, one-entry output register.
// Optional grant lock for multi-word bursts is enabled by defining RR_WORDMUX_LOCK_EN.
module rr_wordmux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic [CHANNELS-1:0]       o_ready,
    output logic                      o_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic [SEL_W-1:0]          o_chan,
    input  logic                      i_ready
`ifdef RR_WORDMUX_LOCK_EN
   ,input  logic                      i_lock
`endif
);

    localparam int EW = SEL_W + 1;

    logic                 out_valid_reg;
    logic [WIDTH-1:0]     out_data_reg;
    logic [SEL_W-1:0]     out_chan_reg;
    logic [SEL_W-1:0]     last_reg;

    logic [WIDTH-1:0]     words [CHANNELS];
    logic                 lock_active;
    logic                 slot_free;
    logic                 win_found;
    logic [SEL_W-1:0]     win_idx;
    logic [EW-1:0]        sum_ext;
    logic [EW-1:0]        cand_ext;
    logic                 grant_en;

`ifdef RR_WORDMUX_LOCK_EN
    assign lock_active = i_lock;
`else
    assign lock_active = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign words[gi] = i_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign slot_free = !out_valid_reg || i_ready;

    // Scan from the farthest offset down so the nearest requester after last_reg wins;
    // offset CHANNELS lands on last_reg itself, giving it the lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum_ext   = '0;
        cand_ext  = '0;
        if (lock_active) begin
            win_found = i_valid[last_reg];
            win_idx   = last_reg;
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                sum_ext  = {1'b0, last_reg} + EW'(k);
                cand_ext = (sum_ext >= EW'(CHANNELS)) ? (sum_ext - EW'(CHANNELS)) : sum_ext;
                if (i_valid[cand_ext[SEL_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand_ext[SEL_W-1:0];
                end
            end
        end
    end

    assign grant_en = slot_free && win_found && !i_rst;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign o_ready[gi] = grant_en && (win_idx == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            last_reg      <= SEL_W'(CHANNELS - 1);
        end else if (grant_en) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= words[win_idx];
            out_chan_reg  <= win_idx;
            last_reg      <= win_idx;
        end else if (i_ready) begin
            // Drained with nothing to refill: keep the stale word, just clear valid.
            out_valid_reg <= 1'b0;
        end
    end

    assign o_valid = out_valid_reg;
    assign o_data  = out_data_reg;
    assign o_chan  = out_chan_reg;

endmodule

// File: tb/tb_rr_wordmux.sv
// Self-checking bench for rr_wordmux: directed scenarios plus random traffic against a
// behavioural round-robin model.
module tb_rr_wordmux;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef RR_WORDMUX_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N*W-1:0] data  = '0;
    logic           rdy   = 1'b0;
    logic           lock  = 1'b0;
    logic [N-1:0]   o_ready;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic [SW-1:0]  o_chan;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_last  = N - 1;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    logic [N-1:0] seen_ready;

    localparam logic [N*W-1:0] FAIR = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    localparam logic [N*W-1:0] BP   = {16'h1003, 16'hBEEF, 16'h1001, 16'h1000};

    rr_wordmux #(.WIDTH(W), .CHANNELS(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_chan  (o_chan),
        .i_ready (rdy)
`ifdef RR_WORDMUX_LOCK_EN
       ,.i_lock  (lock)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational grant, then the registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic r, input logic rs, input logic lk);
        int           g;
        logic [N-1:0] er;
        @(negedge clk);
        valid = v; data = d; rdy = r; rst = rs; lock = lk;
        #1;
        g  = -1;
        er = '0;
        if (!rs && (!m_valid || r)) begin
            if (LOCK_ON && lk) begin
                if (v[m_last]) g = m_last;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (g < 0 && v[c]) g = c;
                end
            end
        end
        if (g >= 0) er[g] = 1'b1;
        seen_ready = o_ready;
        chk("o_ready", 32'(o_ready), 32'(er));
        @(posedge clk);
        #1;
        if (rs) begin
            m_valid = 1'b0; m_data = '0; m_chan = 0; m_last = N - 1;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_data = d[g*W +: W]; m_chan = g; m_last = g;
        end else if (r) begin
            m_valid = 1'b0;
        end
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_data",  32'(o_data),  32'(m_data));
        chk("o_chan",  32'(o_chan),  32'(m_chan));
    endtask

    initial begin
        // Reset held with every channel requesting
        for (int i = 0; i < 3; i++) begin
            step(4'hF, FAIR, 1'b1, 1'b1, 1'b0);
            chk("rst_ready", 32'(seen_ready), 32'h0);
            chk("rst_valid", 32'(o_valid), 32'h0);
        end

        // Fair rotation, first grant to channel 0
        for (int i = 0; i < 6; i++) begin
            step(4'hF, FAIR, 1'b1, 1'b0, 1'b0);
            chk("rot_chan", 32'(o_chan), 32'(i % N));
            chk("rot_data", 32'(o_data), 32'h1000 + 32'(i % N));
        end

        // Back-pressure with channel 2 holding BEEF
        step(4'hF, BP, 1'b1, 1'b0, 1'b0);
        chk("bp_load", 32'(o_data), 32'hBEEF);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, BP, 1'b0, 1'b0, 1'b0);
            chk("bp_hold", 32'(o_data), 32'hBEEF);
            chk("bp_noready", 32'(seen_ready), 32'h0);
        end
        step(4'hF, BP, 1'b1, 1'b0, 1'b0);
        chk("bp_regrant", 32'(seen_ready), 32'h8);

        // Sparse: lone channel 1 back to back, then channel 0
        for (int i = 0; i < 4; i++) begin
            step(4'b0010, FAIR, 1'b1, 1'b0, 1'b0);
            chk("sparse_ready", 32'(seen_ready), 32'h2);
            chk("sparse_chan", 32'(o_chan), 32'h1);
        end
        step(4'b0001, FAIR, 1'b1, 1'b0, 1'b0);
        chk("wrap_chan", 32'(o_chan), 32'h0);

        // Drain without refill keeps the old word
        step(4'b0000, FAIR, 1'b1, 1'b0, 1'b0);
        chk("drain_valid", 32'(o_valid), 32'h0);
        chk("drain_data", 32'(o_data), 32'h1000);

        // Mid-stream reset discards the held word
        step(4'hF, FAIR, 1'b1, 1'b0, 1'b0);
        step(4'hF, FAIR, 1'b0, 1'b1, 1'b0);
        chk("midrst_valid", 32'(o_valid), 32'h0);

        if (LOCK_ON) begin
            step(4'b0100, FAIR, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                step(4'hF, FAIR, 1'b1, 1'b0, 1'b1);
                chk("lock_ready", 32'(seen_ready), 32'h4);
            end
            step(4'hF, FAIR, 1'b1, 1'b0, 1'b0);
            chk("unlock_ready", 32'(seen_ready), 32'h8);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0]   v;
            logic [N*W-1:0] d;
            logic           r, rs, lk;
            v  = N'($urandom);
            d  = {$urandom, $urandom};
            r  = ($urandom % 4) != 0;
            rs = ($urandom % 50) == 0;
            lk = LOCK_ON && (($urandom % 6) == 0);
            step(v, d, r, rs, lk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
